zc_spi_master: RTL

//  Z-Controller-style SPI master driving the SD interface (real or virtual card) from the CPU port side.
//  CPU writes a byte to start an 8-bit full-duplex exchange; CPU reads return the last received byte and start a 0xFF exchange.

---
 rtl/zc_spi_pkg.sv | 21 ++
 rtl/zc_spi_tick.sv | 29 ++
 rtl/zc_spi_master.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/zc_spi_pkg.sv
// Shared types and constants for the Z-Controller SPI master.
// Optional feature macro: ZC_SPI_WAIT_EN (queued access + CPU wait).
package zc_spi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOW,
        ST_HIGH,
        ST_DONE
    } state_e;

    localparam int CTRL_CS_BIT   = 0;
    localparam int CTRL_SLOW_BIT = 1;

    localparam logic [7:0] IDLE_BYTE = 8'hFF;

    function automatic int cnt_width(input int a, input int b);
        return $clog2(((a > b) ? a : b) + 1);
    endfunction

endpackage

// File: rtl/zc_spi_tick.sv
// Loadable down-counter producing a one-cycle tick every H cycles.
// Reloads itself from load_val_i on every tick while enabled.
module zc_spi_tick #(
    parameter int W = 2
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    output logic         tick_o
);

    logic [W-1:0] cnt_q;

    assign tick_o = en_i && (cnt_q == '0);

    // Count down from the loaded value, wrapping to it on each tick.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (en_i) begin
            cnt_q <= (cnt_q == '0) ? load_val_i : cnt_q - 1'b1;
        end
    end

endmodule

// File: rtl/zc_spi_master.sv
// Z-Controller style SPI master (mode 0, MSB first) for the SD card port.
// Optional feature macro: ZC_SPI_WAIT_EN (one queued access + cpu_wait).
module zc_spi_master
    import zc_spi_pkg::*;
#(
    parameter int HALF_FAST = 2,
    parameter int HALF_SLOW = 64
) (
    input  logic       clk_sys,
    input  logic       rst_n,
    input  logic       cfg_we,
    input  logic [1:0] cfg_din,
    input  logic       data_we,
    input  logic       data_rd,
    input  logic [7:0] data_din,
    output logic [7:0] data_dout,
    output logic       busy,
    output logic       cpu_wait,
    output logic       spi_sck,
    output logic       spi_mosi,
    input  logic       spi_miso,
    output logic       spi_cs_n
);

    localparam int CW = cnt_width(HALF_FAST, HALF_SLOW);
    localparam logic [CW-1:0] HF_M1 = CW'(HALF_FAST - 1);
    localparam logic [CW-1:0] HS_M1 = CW'(HALF_SLOW - 1);

    state_e        state_q;
    logic [7:0]    tx_q;
    logic [7:0]    rx_q;
    logic [7:0]    dout_q;
    logic [2:0]    bit_q;
    logic [CW-1:0] h_q;
    logic [CW-1:0] h_new;
    logic          sck_q;
    logic          mosi_q;
    logic          busy_q;
    logic [1:0]    ctrl_q;
    logic [1:0]    cfg_pend_q;
    logic          cfg_pv_q;

    logic          strobe;
    logic          active;
    logic          is_done;
    logic          start_go;
    logic [7:0]    start_byte;
    logic          tick;

    assign strobe  = data_we | data_rd;
    assign active  = (state_q != ST_IDLE);
    assign is_done = (state_q == ST_DONE);
    assign h_new   = ctrl_q[CTRL_SLOW_BIT] ? HS_M1 : HF_M1;

`ifdef ZC_SPI_WAIT_EN
    logic       pend_q;
    logic [7:0] pend_byte_q;

    assign start_go = (!active && (strobe || pend_q))
                    || (is_done && pend_q);
    assign start_byte = pend_q  ? pend_byte_q :
                        data_we ? data_din : IDLE_BYTE;
    assign cpu_wait = pend_q | (active & strobe);

    // Single-slot queue for accesses arriving mid-byte; extras dropped.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            pend_q      <= 1'b0;
            pend_byte_q <= IDLE_BYTE;
        end else if (active && strobe && (!pend_q || start_go)) begin
            pend_q      <= 1'b1;
            pend_byte_q <= data_we ? data_din : IDLE_BYTE;
        end else if (start_go) begin
            pend_q <= 1'b0;
        end
    end
`else
    assign start_go   = !active && strobe;
    assign start_byte = data_we ? data_din : IDLE_BYTE;
    assign cpu_wait   = 1'b0;
`endif

    zc_spi_tick #(
        .W (CW)
    ) u_tick (
        .clk_i      (clk_sys),
        .rst_ni     (rst_n),
        .load_i     (start_go),
        .load_val_i (start_go ? h_new : h_q),
        .en_i       ((state_q == ST_LOW) || (state_q == ST_HIGH)),
        .tick_o     (tick)
    );

    // Control register; writes during a byte wait for its DONE cycle.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q     <= 2'b11;
            cfg_pend_q <= 2'b11;
            cfg_pv_q   <= 1'b0;
        end else if (cfg_we && (!active || is_done)) begin
            ctrl_q   <= cfg_din;
            cfg_pv_q <= 1'b0;
        end else if (cfg_we) begin
            cfg_pend_q <= cfg_din;
            cfg_pv_q   <= 1'b1;
        end else if (is_done && cfg_pv_q) begin
            ctrl_q   <= cfg_pend_q;
            cfg_pv_q <= 1'b0;
        end
    end

    // Byte exchange FSM: alternate SCK half-periods, 8 bits, then DONE.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            tx_q    <= IDLE_BYTE;
            rx_q    <= IDLE_BYTE;
            dout_q  <= IDLE_BYTE;
            bit_q   <= 3'd0;
            h_q     <= HF_M1;
            sck_q   <= 1'b0;
            mosi_q  <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start_go) begin
                        tx_q    <= start_byte;
                        mosi_q  <= start_byte[7];
                        bit_q   <= 3'd0;
                        h_q     <= h_new;
                        busy_q  <= 1'b1;
                        state_q <= ST_LOW;
                    end
                end
                ST_LOW: begin
                    if (tick) begin
                        sck_q   <= 1'b1;
                        rx_q    <= {rx_q[6:0], spi_miso};
                        state_q <= ST_HIGH;
                    end
                end
                ST_HIGH: begin
                    if (tick) begin
                        sck_q <= 1'b0;
                        if (bit_q != 3'd7) begin
                            tx_q    <= {tx_q[6:0], 1'b1};
                            mosi_q  <= tx_q[6];
                            bit_q   <= bit_q + 3'd1;
                            state_q <= ST_LOW;
                        end else begin
                            state_q <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    dout_q <= rx_q;
                    if (start_go) begin
                        tx_q    <= start_byte;
                        mosi_q  <= start_byte[7];
                        bit_q   <= 3'd0;
                        h_q     <= h_new;
                        state_q <= ST_LOW;
                    end else begin
                        mosi_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign data_dout = dout_q;
    assign busy      = busy_q;
    assign spi_sck   = sck_q;
    assign spi_mosi  = mosi_q;
    assign spi_cs_n  = ctrl_q[CTRL_CS_BIT];

endmodule
